llc_cmd_issuer: RTL and testbench

Upstream command stage for the LLC model. Accepts trace commands (operation code plus 32-bit address) from the trace reader, drops illegal opcodes, and buffers legal ones in an in-order FIFO. It issues them to the LLC over a valid/ready handshake. After issuing a clear (op 8) or print (op 9) command, it stalls issue until the LLC reports that command complete.

---
 rtl/llc_cmd_issuer_pkg.sv | 34 +++
 rtl/llc_cmd_issuer_fifo.sv | 59 +++++
 rtl/llc_cmd_issuer.sv | 106 ++++++++++
 tb/tb_llc_cmd_issuer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/llc_cmd_issuer_pkg.sv
// Shared definitions for the LLC trace command issue stage.
// Opcode set, legality check and the buffered command record.
package LLC_defs;

    localparam int LLC_ADDR_W = 32;

    typedef enum logic [3:0] {
        OP_RD       = 4'd0,
        OP_WR       = 4'd1,
        OP_IRD      = 4'd2,
        OP_SNP_RD   = 4'd3,
        OP_SNP_WR   = 4'd4,
        OP_SNP_RWIM = 4'd5,
        OP_SNP_INV  = 4'd6,
        OP_CLEAR    = 4'd8,
        OP_PRINT    = 4'd9
    } llc_op_e;

    typedef struct packed {
        logic [3:0]            op;
        logic [LLC_ADDR_W-1:0] addr;
    } llc_cmd_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_RD, OP_WR, OP_IRD,
            OP_SNP_RD, OP_SNP_WR,
            OP_SNP_RWIM, OP_SNP_INV,
            OP_CLEAR, OP_PRINT: is_legal_op = 1'b1;
            default:            is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/llc_cmd_issuer_fifo.sv
// In-order command FIFO; full/empty come from the entry count.
// Storage is datapath only, so it is not reset.
module llc_cmd_fifo
    import LLC_defs::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = llc_cmd_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/llc_cmd_issuer.sv
// Filters trace commands, buffers legal ones and issues them to the LLC,
// holding issue after a clear or print until the LLC reports it done.
module llc_cmd_issuer
    import LLC_defs::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_op,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    input  logic                   clear_done,
    input  logic                   print_done,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            drop_cnt,
    output logic [31:0]            issued_cnt
);

    typedef struct packed {
        logic [3:0]            op;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_t;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_WAIT_CLR = 2'd1;
    localparam logic [1:0] ST_WAIT_PRT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] drop_q, drop_d;
    logic [31:0] iss_q, iss_d;

    logic full, empty, accept, legal, push, pop;
    cmd_t wcmd, head;

    assign legal    = is_legal_op(in_op);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign wcmd     = '{op: in_op, addr: in_addr};

    assign out_valid = !empty && (state_q == ST_RUN);
    assign pop       = out_valid && out_ready;
    assign out_op    = head.op;
    assign out_addr  = head.addr;
    assign halted    = (state_q != ST_RUN);

    llc_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Done pulses only matter in the state that is waiting for them.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (pop && head.op == OP_CLEAR)      state_d = ST_WAIT_CLR;
                else if (pop && head.op == OP_PRINT) state_d = ST_WAIT_PRT;
            end
            ST_WAIT_CLR: if (clear_done) state_d = ST_RUN;
            ST_WAIT_PRT: if (print_done) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        iss_d  = iss_q;
        if (accept && !legal && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
        if (pop) iss_d = iss_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            drop_q  <= '0;
            iss_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            iss_q   <= iss_d;
        end
    end

    assign drop_cnt   = drop_q;
    assign issued_cnt = iss_q;

endmodule

// File: tb/tb_llc_cmd_issuer.sv
// Directed bench for llc_cmd_issuer: vector table for the FIFO path,
// hand-written sequences for clear/print waits and reset.
module tb_llc_cmd_issuer;

    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_addr;
    logic          out_valid, out_ready;
    logic [3:0]    out_op;
    logic [AW-1:0] out_addr;
    logic          clear_done, print_done, halted;
    logic [$clog2(DEPTH):0] occupancy;
    logic [15:0]   drop_cnt;
    logic [31:0]   issued_cnt;

    int checks   = 0;
    int failures = 0;

    llc_cmd_issuer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_addr   (out_addr),
        .clear_done (clear_done),
        .print_done (print_done),
        .halted     (halted),
        .occupancy  (occupancy),
        .drop_cnt   (drop_cnt),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [31:0] addr;
        logic        ordy;
        logic        ov;
        logic [3:0]  eop;
        logic [31:0] eaddr;
        logic        irdy;
        int          occ;
        int          drop;
        int          iss;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    function automatic vec_t mk(logic iv, logic [3:0] op, logic [31:0] addr,
                                logic ordy, logic ov, logic [3:0] eop,
                                logic [31:0] eaddr, logic irdy, int occ,
                                int drop, int iss);
        vec_t v;
        v.iv = iv; v.op = op; v.addr = addr; v.ordy = ordy;
        v.ov = ov; v.eop = eop; v.eaddr = eaddr; v.irdy = irdy;
        v.occ = occ; v.drop = drop; v.iss = iss;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] op,
                         input logic [31:0] addr, input logic ordy,
                         input logic cd, input logic pd);
        in_valid   = iv;
        in_op      = op;
        in_addr    = addr;
        out_ready  = ordy;
        clear_done = cd;
        print_done = pd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected values are "after the edge that samples these inputs".
        vt[0] = mk(1, 0, 32'h1000, 1, 1, 0, 32'h1000, 1, 1, 0, 0);
        vt[1] = mk(1, 1, 32'h2000, 1, 1, 1, 32'h2000, 1, 1, 0, 1);
        vt[2] = mk(1, 2, 32'h3000, 1, 1, 2, 32'h3000, 1, 1, 0, 2);
        vt[3] = mk(0, 0, 32'h0,    1, 0, 0, 32'h0,    1, 0, 0, 3);
        vt[4] = mk(1, 7, 32'h7777, 1, 0, 0, 32'h0,    1, 0, 1, 3);
        vt[5] = mk(1, 12, 32'hC,   1, 0, 0, 32'h0,    1, 0, 2, 3);
        for (int i = 0; i < 8; i++)
            vt[6+i] = mk(1, 4'(i % 3), 32'h100 + i, 0,
                         1, 0, 32'h100, (i < 7), i + 1, 2, 3);
        vt[14] = mk(1, 4, 32'h500, 1, 1, 1, 32'h101, 1, 7, 2, 4);
        vt[15] = mk(1, 4, 32'h500, 0, 1, 1, 32'h101, 0, 8, 2, 4);
        for (int k = 2; k < 8; k++)
            vt[14+k] = mk(0, 0, 32'h0, 1, 1, 4'(k % 3), 32'h100 + k,
                          1, 9 - k, 2, k + 3);
        vt[22] = mk(0, 0, 32'h0, 1, 1, 4, 32'h500, 1, 1, 2, 11);
        vt[23] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0,   1, 0, 2, 12);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_halted",    32'(halted), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_occ",       32'(occupancy), 0);
        chk("rst_drop",      32'(drop_cnt), 0);
        chk("rst_issued",    issued_cnt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].iv, vt[i].op, vt[i].addr, vt[i].ordy, 0, 0);
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].irdy));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vt[i].occ));
            chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vt[i].drop));
            chk($sformatf("v%0d_issued", i), issued_cnt, 32'(vt[i].iss));
            chk($sformatf("v%0d_halted", i), 32'(halted), 0);
            if (vt[i].ov) begin
                chk($sformatf("v%0d_out_op", i), 32'(out_op), 32'(vt[i].eop));
                chk($sformatf("v%0d_out_addr", i), out_addr, vt[i].eaddr);
            end
        end

        // Clear: op 8 issues, op 3 held until clear_done.
        drive(1, 8, 32'h8, 1, 0, 0);
        tick();
        chk("clr_a_valid", 32'(out_valid), 1);
        chk("clr_a_op", 32'(out_op), 8);
        drive(1, 3, 32'hABCD0000, 1, 0, 0);
        tick();
        chk("clr_b_halted", 32'(halted), 1);
        chk("clr_b_valid", 32'(out_valid), 0);
        chk("clr_b_occ", 32'(occupancy), 1);
        chk("clr_b_issued", issued_cnt, 13);
        chk("clr_b_head", out_addr, 32'hABCD0000);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("clr_c_halted", 32'(halted), 1);
        chk("clr_c_valid", 32'(out_valid), 0);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("clr_d_halted", 32'(halted), 0);
        chk("clr_d_valid", 32'(out_valid), 1);
        chk("clr_d_op", 32'(out_op), 3);
        chk("clr_d_issued", issued_cnt, 13);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("clr_e_occ", 32'(occupancy), 0);
        chk("clr_e_issued", issued_cnt, 14);

        // Print: same-cycle and wrong done pulses are ignored.
        drive(1, 9, 32'h9, 0, 0, 0);
        tick();
        chk("prt_f_valid", 32'(out_valid), 1);
        drive(0, 0, 0, 1, 0, 1);
        tick();
        chk("prt_g_halted", 32'(halted), 1);
        chk("prt_g_issued", issued_cnt, 15);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("prt_h_halted", 32'(halted), 1);
        drive(0, 0, 0, 1, 0, 1);
        tick();
        chk("prt_i_halted", 32'(halted), 0);

        // Reset while waiting on a print with four entries buffered.
        drive(1, 9, 32'h99, 0, 0, 0);
        tick();
        chk("rs_j_occ", 32'(occupancy), 1);
        drive(1, 0, 32'h10, 1, 0, 0);
        tick();
        chk("rs_k_halted", 32'(halted), 1);
        chk("rs_k_issued", issued_cnt, 16);
        for (int i = 1; i < 4; i++) begin
            drive(1, 4'(i), 32'h10 + i, 1, 0, 0);
            tick();
        end
        chk("rs_n_occ", 32'(occupancy), 4);
        chk("rs_n_valid", 32'(out_valid), 0);
        rst_n = 1'b0;
        drive(1, 1, 32'h77, 1, 0, 0);
        tick();
        chk("rs_o_occ", 32'(occupancy), 0);
        chk("rs_o_halted", 32'(halted), 0);
        chk("rs_o_valid", 32'(out_valid), 0);
        chk("rs_o_in_ready", 32'(in_ready), 1);
        chk("rs_o_drop", 32'(drop_cnt), 0);
        chk("rs_o_issued", issued_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
